// File: rtl/dac_table_8x_hls_deadlock_monitor_param_if.sv
// Signal bundle between a dataflow region and its deadlock monitor.
// The monitor sits on the slave side; the region/debug logic sits on the master side.
interface dac_table_8x_hls_deadlock_monitor_param_if #(
    parameter int N_AXIS = 3,
    parameter int N_INST = 1,
    parameter int CNT_W  = 16,
    parameter int EVT_W  = 8
);
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_INST-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              clear;
    logic              block;
    logic [N_AXIS-1:0] block_axis_mask;
    logic [N_INST-1:0] block_inst_mask;
    logic [CNT_W-1:0]  stall_cycles;
    logic [EVT_W-1:0]  event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_axis_mask, block_inst_mask, stall_cycles, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_axis_mask, block_inst_mask, stall_cycles, event_count
    );
endinterface

// File: rtl/dac_table_8x_hls_deadlock_monitor_param.sv
// Parametrised HLS dataflow deadlock monitor: persistence threshold, sticky mode,
// offender snapshot at detection and a saturating detection-event counter.
module dac_table_8x_hls_deadlock_monitor_param #(
    parameter int N_AXIS = 3,
    parameter int N_INST = 1,
    parameter int THRESH = 1,
    parameter int CNT_W  = 16,
    parameter bit STICKY = 1'b0,
    parameter int EVT_W  = 8
) (
    input  logic clock,
    input  logic reset_n,
    dac_table_8x_hls_deadlock_monitor_param_if.slave mon
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [EVT_W-1:0] EVT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    // Assertion is immediate; deassertion reaches the logic via two flops.
    logic [1:0] rst_sync_reg;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end

    logic run;
    assign run = rst_sync_reg[1];

    // An idle instance is never treated as blocked.
    logic [N_INST-1:0] qi;
    genvar gi;
    generate
        for (gi = 0; gi < N_INST; gi++) begin : g_qual
            assign qi[gi] = mon.inst_block_sigs[gi] & ~mon.inst_idle_sigs[gi];
        end
    endgenerate

    logic              stall;
    logic              det;
    logic              rise;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic              block_reg, block_next;
    logic [N_AXIS-1:0] amask_reg, amask_next;
    logic [N_INST-1:0] imask_reg, imask_next;
    logic [EVT_W-1:0]  evt_reg,   evt_next;

    always_comb begin
        stall      = (|mon.axis_block_sigs) | (|qi);
        cnt_next   = '0;
        block_next = 1'b0;
        amask_next = amask_reg;
        imask_next = imask_reg;
        evt_next   = evt_reg;
        if (!mon.clear && stall)
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        det = (cnt_next >= THRESH_C);
        if (!mon.clear)
            block_next = STICKY ? (block_reg | det) : det;
        rise = block_next & ~block_reg;
        if (mon.clear) begin
            amask_next = '0;
            imask_next = '0;
            evt_next   = '0;
        end else if (rise) begin
            amask_next = mon.axis_block_sigs;
            imask_next = qi;
            if (evt_reg != EVT_MAX) evt_next = evt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            block_reg <= 1'b0;
            amask_reg <= '0;
            imask_reg <= '0;
            evt_reg   <= '0;
        end else if (!run) begin
            cnt_reg   <= '0;
            block_reg <= 1'b0;
            amask_reg <= '0;
            imask_reg <= '0;
            evt_reg   <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            block_reg <= block_next;
            amask_reg <= amask_next;
            imask_reg <= imask_next;
            evt_reg   <= evt_next;
        end
    end

    assign mon.block           = block_reg;
    assign mon.block_axis_mask = amask_reg;
    assign mon.block_inst_mask = imask_reg;
    assign mon.stall_cycles    = cnt_reg;
    assign mon.event_count     = evt_reg;
endmodule
